// File: rtl/filter_pkg.sv
// Shared definitions for the coefficient loader and digital_filter.
package filter_pkg;

  localparam int DEFAULT_COEFF_WIDTH = 16;
  localparam int DEFAULT_NUM_TAPS    = 32;

  typedef logic signed [DEFAULT_COEFF_WIDTH-1:0] coeff_t;

  typedef enum logic {
    LD_FILL,
    LD_PENDING
  } ld_state_e;

endpackage

// File: rtl/filter_coeff_loader_if.sv
// Valid/ready coefficient stream feeding the loader.
interface filter_coeff_loader_if
  import filter_pkg::*;
#(
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH
);

  logic                   s_valid;
  logic                   s_ready;
  logic [COEFF_WIDTH-1:0] s_data;
  logic                   s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/coeff_shadow_bank.sv
// Shadow register file: one indexed write port, full parallel read.
module coeff_shadow_bank
  import filter_pkg::*;
#(
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
  parameter int NUM_TAPS    = DEFAULT_NUM_TAPS,
  localparam int IDX_W      = $clog2(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              waddr_i,
  input  logic signed [COEFF_WIDTH-1:0] wdata_i,
  output logic signed [COEFF_WIDTH-1:0] rdata_o [NUM_TAPS]
);

  logic signed [COEFF_WIDTH-1:0] mem_q [NUM_TAPS];

  // Indexed write of one tap per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/filter_coeff_loader.sv
// Coefficient loader: fills a shadow bank from a stream and commits the
// whole set to the active bank atomically when swap_en allows.
module filter_coeff_loader
  import filter_pkg::*;
#(
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
  parameter int NUM_TAPS    = DEFAULT_NUM_TAPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  filter_coeff_loader_if.slave          s,
  input  logic                          swap_en,
  output logic signed [COEFF_WIDTH-1:0] coeff [NUM_TAPS],
  output logic                          load_done,
  output logic                          load_err,
  output logic                          pending
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  ld_state_e                     state_q;
  logic [IDX_W-1:0]              cnt_q;
  logic signed [COEFF_WIDTH-1:0] coeff_q   [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_rd [NUM_TAPS];
  logic                          done_q;
  logic                          err_q;

  logic accept;
  logic at_last;
  logic shadow_we;

  // Handshake decode; a beat past the last tap (long set) is never written
  always_comb begin
    accept    = s.s_valid && (state_q == LD_FILL);
    at_last   = (cnt_q == LAST_IDX);
    shadow_we = accept && !(at_last && !s.s_last);
  end

  assign s.s_ready = (state_q == LD_FILL);

  coeff_shadow_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (shadow_we),
    .waddr_i (cnt_q),
    .wdata_i (s.s_data),
    .rdata_o (shadow_rd)
  );

  // Loader FSM, tap counter, active bank and result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_FILL;
      cnt_q   <= '0;
      coeff_q <= '{default: '0};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        LD_FILL: begin
          if (accept) begin
            if (s.s_last) begin
              cnt_q <= '0;
              if (at_last) state_q <= LD_PENDING;
              else         err_q   <= 1'b1;
            end else if (at_last) begin
              cnt_q <= '0;
              err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        LD_PENDING: begin
          if (swap_en) begin
            coeff_q <= shadow_rd;
            state_q <= LD_FILL;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= LD_FILL;
      endcase
    end
  end

  assign coeff     = coeff_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign pending   = (state_q == LD_PENDING);

endmodule

// File: doc/filter_coeff_loader.md
# filter_coeff_loader

Coefficient loader sitting directly upstream of `digital_filter`, driving its `coeff` array. It accepts one complete set of `NUM_TAPS` coefficients over a valid/ready stream into a shadow bank. It then commits the set atomically to the active bank, which drives the filter, only when `swap_en` permits. The filter therefore never sees a partially written tap set.

## Interface
- `COEFF_WIDTH`, 16, coefficient width in bits (two's complement, matches filter)
- `NUM_TAPS`, 32, taps per set; must be ≥ 2
- `IDX_W`, `$clog2(NUM_TAPS)`, localparam, tap index width

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  coefficient beat valid
- `s_ready`  out  1  loader can accept a beat
- `s_data`  in  `COEFF_WIDTH`  coefficient, tap 0 first
- `s_last`  in  1  marks final beat of a set
- `swap_en`  in  1  commit permitted this cycle (filter frame boundary)
- `coeff`  out  `NUM_TAPS` × `COEFF_WIDTH`  active bank, unpacked array, index = tap number
- `load_done`  out  1  one-cycle pulse after a commit
- `load_err`  out  1  one-cycle pulse after a malformed set is discarded
- `pending`  out  1  complete set waiting for `swap_en`

## Operation
- Beat accepted when `s_valid && s_ready` at a rising edge.
- Accepted `s_data` is written to `shadow[cnt]`, then `cnt` increments.
- States:
  - FILL: `s_ready` = 1.
  - PENDING: `s_ready` = 0, `pending` = 1.
- FILL transitions:
  - Accepted beat with `cnt == NUM_TAPS-1` and `s_last == 1`: write the beat, set `cnt` to 0, go to PENDING.
  - Accepted beat with `s_last == 1` and `cnt != NUM_TAPS-1` (short set): set `cnt` to 0, pulse `load_err`, stay in FILL. Shadow contents are don't-care.
  - Accepted beat with `cnt == NUM_TAPS-1` and `s_last == 0` (long set): discard the beat, set `cnt` to 0, pulse `load_err`, stay in FILL. The following beats start a new set at tap 0.
- PENDING transitions:
  - `swap_en == 1` at an edge: copy all `NUM_TAPS` shadow entries to `coeff` in that single edge, go to FILL.
  - `load_done` is high the following cycle.
  - `swap_en == 0`: hold. `coeff` is unchanged.
- `coeff` changes only on a commit edge or on reset; never per-tap.
- `s_data` is stored verbatim: no arithmetic, no saturation.

## Timing
- Reset (async assert, released on a clock edge):
  - All `coeff` taps = 0, so the filter output is 0.
  - Shadow = 0, `cnt` = 0, state = FILL.
  - `s_ready` = 1, `load_done` = 0, `load_err` = 0, `pending` = 0.
- `s_ready` is decoded from state only and does not depend on `s_valid`. It is 0 for every PENDING cycle.
- The completing beat and `swap_en` high in the same cycle do not commit. The earliest commit is the next edge, so the minimum latency from last beat to new `coeff` is 2 edges.
- `load_done` / `load_err` are registered, one cycle wide, with no overlap.
- Reset mid-load or during PENDING: partial/pending shadow lost, `coeff` returns to zeros, no `load_done`.
- `s_valid` low mid-set: `cnt` holds; gaps of any length are allowed.
- Back-to-back sets: the next set's tap 0 can be accepted in the cycle after the commit edge.

## Structure
- Shared package `filter_pkg`: default `COEFF_WIDTH` and `NUM_TAPS` constants, `coeff_t` typedef (logic signed [COEFF_WIDTH-1:0]), and the loader state enum (`LD_FILL`, `LD_PENDING`).
- The same package is used by `digital_filter` so the widths agree.
- One sub-module: `coeff_shadow_bank`, a `NUM_TAPS`-entry register file with indexed write and full parallel read.
- The top level holds the FSM, the counter, and the active bank.

## Test plan
- Reset, then load taps `k+1` (k = 0..31) with `s_last` on beat 31, `swap_en` = 0 → `pending` = 1, `s_ready` = 0, `coeff` all 0. Raise `swap_en` for one cycle → `coeff[k]` = `k+1`, then `load_done` for one cycle.
- Short set (`s_last` on beat 9) → `load_err` pulse, `coeff` unchanged, next full set of `16'h7FFF` commits correctly.
- Long set (beat 31 without `s_last`) → `load_err` pulse. Beat 32 is treated as tap 0 of a new set.
- Random `s_valid` gaps and `swap_en` asserted on the last-beat cycle → commit occurs exactly one edge later, data intact.
- Assert `rst_n` low at beat 15, and separately during PENDING → `coeff` all 0 asynchronously, `cnt` = 0, no `load_done`.
